serial_lut_loader: RTL and testbench

//   Sequencer that fills the serial-load LUT's 2**IN_WIDTH x OUT_WIDTH shift-register table.

---
 rtl/serial_lut_loader_if.sv | 22 ++
 rtl/serial_lut_loader.sv | 159 +++++++++++++++
 tb/tb_serial_lut_loader.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_lut_loader_if.sv
// serial_lut_loader_if
//   Table-entry write port of the serial LUT loader: the host offers one
//   OUT_WIDTH-bit entry with wr_valid, the loader takes it when wr_ready is high.
interface serial_lut_loader_if #(
    parameter int OUT_WIDTH = 3
);
    logic                 wr_valid;
    logic [OUT_WIDTH-1:0] wr_data;
    logic                 wr_ready;

    modport master (
        output wr_valid,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/serial_lut_loader.sv
// serial_lut_loader
//   Fills a 2**IN_WIDTH x OUT_WIDTH serial-load LUT. Each entry taken over the
//   valid/ready write port is shifted out MSB-first on sr_d while sr_cs_n is low;
//   after NUM_ENT entries a one-cycle done pulse is produced.
//   Optional feature macro: LUT_LOADER_ROT_EN adds the rot_req input and a
//   one-cycle ROT state that drives sr_rot_n low; without it sr_rot_n stays 1.
module serial_lut_loader #(
    parameter int IN_WIDTH  = 4,
    parameter int OUT_WIDTH = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
`ifdef LUT_LOADER_ROT_EN
    input  logic                rot_req,
`endif
    serial_lut_loader_if.slave  wr,
    output logic                sr_d,
    output logic                sr_cs_n,
    output logic                sr_rot_n,
    output logic                busy,
    output logic                done,
    output logic [IN_WIDTH:0]   ent_cnt
);

    localparam int NUM_ENT = 1 << IN_WIDTH;
    localparam int BIT_W   = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;

    // Index of the last serial bit of an entry, and the count value that marks
    // the final entry of a table (checked before the increment lands).
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(OUT_WIDTH - 1);
    localparam logic [IN_WIDTH:0] LAST_ENT = (IN_WIDTH + 1)'(NUM_ENT - 1);
    localparam logic [IN_WIDTH:0] ONE_ENT  = (IN_WIDTH + 1)'(1);
    localparam logic [BIT_W-1:0]  ONE_BIT  = BIT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
`ifdef LUT_LOADER_ROT_EN
        ST_FIN   = 3'd3,
        ST_ROT   = 3'd4
`else
        ST_FIN   = 3'd3
`endif
    } state_t;

    state_t               state_r;
    logic [OUT_WIDTH-1:0] hold_r;
    logic [BIT_W-1:0]     bit_cnt_r;

    // Loader FSM; every output is a register so the LUT sees clean levels.
    // abort overrides all other inputs and leaves ent_cnt frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            hold_r      <= {OUT_WIDTH{1'b0}};
            bit_cnt_r   <= {BIT_W{1'b0}};
            wr.wr_ready <= 1'b0;
            sr_d        <= 1'b0;
            sr_cs_n     <= 1'b1;
            sr_rot_n    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            ent_cnt     <= {(IN_WIDTH + 1){1'b0}};
        end else if (abort) begin
            state_r     <= ST_IDLE;
            wr.wr_ready <= 1'b0;
            sr_d        <= 1'b0;
            sr_cs_n     <= 1'b1;
            sr_rot_n    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // start beats a simultaneous rot_req
                        state_r     <= ST_LOAD;
                        wr.wr_ready <= 1'b1;
                        busy        <= 1'b1;
                        ent_cnt     <= {(IN_WIDTH + 1){1'b0}};
`ifdef LUT_LOADER_ROT_EN
                    end else if (rot_req) begin
                        state_r  <= ST_ROT;
                        sr_rot_n <= 1'b0;
                        busy     <= 1'b1;
`endif
                    end else begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end

                ST_LOAD: begin
                    if (wr.wr_valid && wr.wr_ready) begin
                        // MSB goes out in the first shift cycle straight from the port
                        hold_r      <= wr.wr_data;
                        sr_d        <= wr.wr_data[OUT_WIDTH-1];
                        sr_cs_n     <= 1'b0;
                        wr.wr_ready <= 1'b0;
                        bit_cnt_r   <= {BIT_W{1'b0}};
                        state_r     <= ST_SHIFT;
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end

                ST_SHIFT: begin
                    if (bit_cnt_r == LAST_BIT) begin
                        sr_cs_n <= 1'b1;
                        sr_d    <= 1'b0;
                        ent_cnt <= ent_cnt + ONE_ENT;
                        if (ent_cnt == LAST_ENT) begin
                            state_r <= ST_FIN;
                            done    <= 1'b1;
                        end else begin
                            state_r     <= ST_LOAD;
                            wr.wr_ready <= 1'b1;
                        end
                    end else begin
                        // hold_r[MSB] was already sent; walk the lower bits up
                        bit_cnt_r <= bit_cnt_r + ONE_BIT;
                        sr_d      <= hold_r[OUT_WIDTH-2];
                        hold_r    <= {hold_r[OUT_WIDTH-2:0], 1'b0};
                        state_r   <= ST_SHIFT;
                    end
                end

                ST_FIN: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end

`ifdef LUT_LOADER_ROT_EN
                ST_ROT: begin
                    sr_rot_n <= 1'b1;
                    busy     <= 1'b0;
                    state_r  <= ST_IDLE;
                end
`endif

                default: begin
                    state_r     <= ST_IDLE;
                    wr.wr_ready <= 1'b0;
                    sr_d        <= 1'b0;
                    sr_cs_n     <= 1'b1;
                    sr_rot_n    <= 1'b1;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_lut_loader.sv
// tb_serial_lut_loader
//   Scoreboard bench: stimulus pushes expected serial bits, expected tables and
//   expected output snapshots into queues; one monitor at the falling edge pops
//   and compares. A behavioural LUT shift register receives sr_d/sr_cs_n/sr_rot_n.
module tb_serial_lut_loader;
    localparam int  IN_WIDTH  = 4;
    localparam int  OUT_WIDTH = 3;
    localparam int  NUM_ENT   = 16;
    localparam time PERIOD    = 10;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
`ifdef LUT_LOADER_ROT_EN
    logic       rot_req = 1'b0;
    bit         rot_mid_en = 1'b0;
    bit         rot_with_start = 1'b0;
`endif
    logic       sr_d, sr_cs_n, sr_rot_n, busy, done;
    logic [4:0] ent_cnt;

    serial_lut_loader_if #(.OUT_WIDTH(OUT_WIDTH)) bus ();

    serial_lut_loader #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
`ifdef LUT_LOADER_ROT_EN
        .rot_req  (rot_req),
`endif
        .wr       (bus),
        .sr_d     (sr_d),
        .sr_cs_n  (sr_cs_n),
        .sr_rot_n (sr_rot_n),
        .busy     (busy),
        .done     (done),
        .ent_cnt  (ent_cnt)
    );

    always #(PERIOD / 2) clk = ~clk;

    // LUT model: shift in on cs_n, rotate right by one entry on rot_n.
    logic [47:0] lut = 48'd0;
    always @(posedge clk) begin
        if (!sr_cs_n)       lut <= {lut[46:0], sr_d};
        else if (!sr_rot_n) lut <= {lut[2:0], lut[47:3]};
    end

    typedef enum int {K_SNAP, K_TIMEOUT, K_EMPTY, K_LUTENT, K_ROTCNT} kind_t;
    typedef struct {
        kind_t      kind;
        string      name;
        logic       cs_n, rot_n, bsy, rdy, dn, d;
        bit         chk_d;
        logic [4:0] cnt;
        int         val;
        int         sel;
    } exp_t;
    typedef struct {
        logic [47:0] tab;
        bit          chk_lat;
        int          cs_base;
    } tab_t;

    exp_t snap_q[$];
    tab_t tab_q[$];
    logic bit_q[$];

    int   checks = 0;
    int   errors = 0;
    int   cs_total = 0;
    int   rot_total = 0;
    time  start_t = 0;
    exp_t em;
    tab_t tm;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: consumes every expectation queue at the falling edge.
    always @(negedge clk) begin
        while (snap_q.size() > 0) begin
            em = snap_q.pop_front();
            case (em.kind)
                K_SNAP: begin
                    chk({em.name, " sr_cs_n"},  sr_cs_n,      em.cs_n);
                    chk({em.name, " sr_rot_n"}, sr_rot_n,     em.rot_n);
                    chk({em.name, " busy"},     busy,         em.bsy);
                    chk({em.name, " wr_ready"}, bus.wr_ready, em.rdy);
                    chk({em.name, " done"},     done,         em.dn);
                    chk({em.name, " ent_cnt"},  ent_cnt,      em.cnt);
                    if (em.chk_d) chk({em.name, " sr_d"}, sr_d, em.d);
                end
                K_TIMEOUT: begin
                    checks++;
                    errors++;
                    $display("FAIL %s: no response within %0d cycles", em.name, em.val);
                end
                K_EMPTY: begin
                    chk("leftover serial bits", bit_q.size(), 0);
                    chk("leftover tables", tab_q.size(), 0);
                end
                K_LUTENT: chk(em.name, lut[em.sel*3 +: 3], em.val);
                K_ROTCNT: chk(em.name, rot_total, em.val);
                default: ;
            endcase
        end

        if (!sr_cs_n) begin
            cs_total++;
            if (bit_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected shift: sr_cs_n low, expected high");
            end else begin
                chk("serial bit", sr_d, bit_q.pop_front());
            end
        end
        if (!sr_rot_n) rot_total++;

        chk("cs_n and rot_n both low", (!sr_cs_n && !sr_rot_n) ? 1 : 0, 0);
        chk("wr_ready outside load", (bus.wr_ready && (!sr_cs_n || !busy || done)) ? 1 : 0, 0);

        if (done) begin
            if (tab_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected done: done=1, expected 0");
            end else begin
                tm = tab_q.pop_front();
                for (int i = 0; i < NUM_ENT; i++)
                    chk($sformatf("lut[%0d]", i), lut[i*3 +: 3], tm.tab[i*3 +: 3]);
                chk("ent_cnt at done", ent_cnt, 16);
                chk("shift cycles per load", cs_total - tm.cs_base, 48);
                if (tm.chk_lat) chk("done latency", int'(($time - start_t) / PERIOD), 64);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap(input string nm, input logic cs_n, input logic rot_n, input logic bsy,
                        input logic rdy, input logic dn, input logic [4:0] cnt);
        exp_t e;
        e.kind = K_SNAP; e.name = nm; e.cs_n = cs_n; e.rot_n = rot_n; e.bsy = bsy;
        e.rdy = rdy; e.dn = dn; e.cnt = cnt; e.d = 1'b0; e.chk_d = 1'b0; e.val = 0; e.sel = 0;
        snap_q.push_back(e);
    endtask

    task automatic push_misc(input kind_t k, input string nm, input int val, input int sel);
        exp_t e;
        e.kind = k; e.name = nm; e.val = val; e.sel = sel; e.chk_d = 1'b0;
        e.cs_n = 1'b1; e.rot_n = 1'b1; e.bsy = 1'b0; e.rdy = 1'b0; e.dn = 1'b0; e.d = 1'b0; e.cnt = 5'd0;
        snap_q.push_back(e);
    endtask

    function automatic logic [47:0] mk_tab(input int mul, input int add);
        logic [47:0] t;
        for (int i = 0; i < NUM_ENT; i++) t[i*3 +: 3] = 3'((i * mul + add) % 8);
        return t;
    endfunction

    // Offer one entry after 'gap' idle cycles; expect nbits of it on sr_d.
    task automatic send_entry(input logic [2:0] v, input int gap, input int nbits);
        int n;
        if (gap > 0) begin
            bus.wr_valid = 1'b0;
            repeat (gap) tick();
        end
        bus.wr_valid = 1'b1;
        bus.wr_data  = v;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (bus.wr_ready) break;
            n++;
            if (n > 20) begin
                push_misc(K_TIMEOUT, "entry handshake", 20, 0);
                tick();
                return;
            end
        end
        tick();
        for (int b = 0; b < nbits; b++) bit_q.push_back(v[2 - b]);
    endtask

    task automatic full_load(input logic [47:0] tab, input bit lat, input bit gaps);
        tab_t t;
        int   n;
        t.tab = tab; t.chk_lat = lat; t.cs_base = cs_total;
        tab_q.push_back(t);
        start = 1'b1;
`ifdef LUT_LOADER_ROT_EN
        if (rot_with_start) rot_req = 1'b1;
`endif
        @(posedge clk);
        start_t = $time;
        #1;
        start = 1'b0;
`ifdef LUT_LOADER_ROT_EN
        rot_req = 1'b0;
`endif
        for (int i = NUM_ENT - 1; i >= 0; i--) begin
`ifdef LUT_LOADER_ROT_EN
            if (rot_mid_en && i == 8) rot_req = 1'b1;
            if (i == 6) rot_req = 1'b0;
`endif
            send_entry(tab[i*3 +: 3], gaps ? (i * 5 + 3) % 6 : 0, 3);
        end
        bus.wr_valid = 1'b0;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (done) break;
            n++;
            if (n > 40) begin
                push_misc(K_TIMEOUT, "done pulse", 40, 0);
                break;
            end
        end
        tick();
        snap("idle after load", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd16);
        tick();
    endtask

    // Watchdog: never hang.
    initial begin
        #(PERIOD * 20000);
        $display("FAIL watchdog: simulation did not reach its end, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed tests ----------------
    initial begin
        exp_t r;
        bus.wr_valid = 1'b0;
        bus.wr_data  = 3'd0;
        #1;
        // reset values while rst_n is held low
        r.kind = K_SNAP; r.name = "reset"; r.cs_n = 1'b1; r.rot_n = 1'b1; r.bsy = 1'b0;
        r.rdy = 1'b0; r.dn = 1'b0; r.cnt = 5'd0; r.d = 1'b0; r.chk_d = 1'b1; r.val = 0; r.sel = 0;
        snap_q.push_back(r);
        #21;
        rst_n = 1'b1;
        tick();
        tick();

        // 1: held-valid load of k mod 8, latency 64
        full_load(mk_tab(1, 0), 1'b1, 1'b0);

        // 3: abort during the first bit of the 6th entry
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 15; i >= 11; i--) send_entry(3'((i * 3 + 1) % 8), 0, 3);
        send_entry(3'((10 * 3 + 1) % 8), 0, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        bus.wr_valid = 1'b0;
        snap("after abort", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5);
        repeat (8) tick();
        full_load(mk_tab(7, 3), 1'b1, 1'b0);

        // 4: start mid-load is ignored, then async reset mid-SHIFT
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 15; i >= 13; i--) send_entry(3'(i % 8), 0, 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        send_entry(3'd4, 0, 3);
        send_entry(3'd3, 0, 3);
        snap("start ignored", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4);
        tick();
        #1;
        rst_n = 1'b0;
        bit_q.delete();
        r.name = "async reset";
        snap_q.push_back(r);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.wr_valid = 1'b0;
        repeat (3) tick();
        snap("idle after reset", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        tick();

        // 2: load with gaps on wr_valid
        full_load(mk_tab(1, 0), 1'b0, 1'b1);

`ifdef LUT_LOADER_ROT_EN
        // 5: load k mod 8, rot_req during the load ignored, then one rotation
        rot_mid_en = 1'b1;
        full_load(mk_tab(1, 0), 1'b1, 1'b0);
        rot_mid_en = 1'b0;
        push_misc(K_ROTCNT, "rotations during load", 0, 0);
        rot_req = 1'b1;
        tick();
        rot_req = 1'b0;
        snap("rot active", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd16);
        tick();
        push_misc(K_LUTENT, "sel15 after rot", 0, 15);
        push_misc(K_LUTENT, "sel3 after rot", 4, 3);
        push_misc(K_ROTCNT, "rotation count", 1, 0);
        snap("idle after rot", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd16);
        tick();

        // 6: start and rot_req together, load wins, no rotation
        rot_with_start = 1'b1;
        full_load(mk_tab(5, 2), 1'b1, 1'b0);
        rot_with_start = 1'b0;
        push_misc(K_ROTCNT, "rotation count after start+rot", 1, 0);
        tick();
`endif

        push_misc(K_EMPTY, "queues", 0, 0);
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
